chunked_addsub: RTL and testbench

- Multi-cycle, parametrised adder/subtractor for the multiply-division datapath.
- Processes a `parallelism`-bit operand pair in `chunk`-bit slices, one slice per clock, with a registered carry between slices.
- Trades latency for a short carry chain.
- Provides a start/done handshake, add/subtract mode, carry-out and signed overflow.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/adder_cout.sv | 22 ++
 rtl/chunked_addsub.sv | 111 +++++++++++
 tb/tb_chunked_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice index; never narrower than one bit.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/adder_cout.sv
// Combinational chunk-wide adder that also reports the carry into its MSB,
// which the parent needs for signed overflow on the final slice.
module adder_cout #(
    parameter int width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [width:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};
    assign s    = full[width-1:0];
    assign cout = full[width];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign cmsb = s[width-1] ^ a[width-1] ^ b[width-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one chunk-wide slice per clock with a registered
// carry between slices, start/done handshake, carry-out and signed overflow.
//
// state | meaning
// IDLE  | ready for a new operation, results held
// RUN   | processing one slice per clock
// DONE  | one-cycle done pulse, results valid
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int parallelism = 16,
    parameter int chunk       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [parallelism-1:0] add1,
    input  logic [parallelism-1:0] add0,
    input  logic                   carry_in,
    output logic                   ready,
    output logic                   done,
    output logic [parallelism-1:0] sum,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int NUM_CHUNKS = parallelism / chunk;
    localparam int IW         = idx_width(NUM_CHUNKS);

    generate
        if ((parallelism % chunk) != 0) begin : g_bad_chunk
            $error("chunked_addsub: chunk must divide parallelism exactly");
        end
    endgenerate

    state_t                 state, state_next;
    logic [IW-1:0]          idx;
    logic [parallelism-1:0] op_a, op_b;
    logic                   carry;
    logic [chunk-1:0]       a_slice, b_slice, s_slice;
    logic                   slice_cout, slice_cmsb;
    logic                   last;

    assign a_slice = op_a[idx*chunk +: chunk];
    assign b_slice = op_b[idx*chunk +: chunk];
    assign last    = (idx == IW'(NUM_CHUNKS - 1));

    adder_cout #(.width(chunk)) u_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .s    (s_slice),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= add1;
                        op_b  <= sub ? ~add0 : add0;
                        carry <= carry_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[idx*chunk +: chunk] <= s_slice;
                    carry <= slice_cout;
                    idx   <= idx + IW'(1);
                    if (last) begin
                        carry_out <= slice_cout;
                        overflow  <= slice_cmsb ^ slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_chunked_addsub;

    localparam int P = 16;
    localparam int C = 4;
    localparam int N = P / C;

    logic         clk = 1'b0;
    logic         rst, start, sub, carry_in;
    logic [P-1:0] add1, add0, sum;
    logic         ready, done, carry_out, overflow;

    chunked_addsub #(.parallelism(P), .chunk(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .add1      (add1),
        .add0      (add0),
        .carry_in  (carry_in),
        .ready     (ready),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic exp_t model(input logic [P-1:0] a, input logic [P-1:0] b,
                                   input logic s, input logic cin);
        exp_t         e;
        logic [P-1:0] bb;
        longint       u, sr;
        bb    = s ? ~b : b;
        u     = longint'(a) + longint'(bb) + longint'(cin);
        sr    = longint'($signed(a)) + longint'($signed(bb)) + longint'(cin);
        e.s   = u[P-1:0];
        e.co  = ((u >> P) & 1) != 0;
        e.ov  = (sr > ((64'sd1 <<< (P-1)) - 1)) || (sr < -(64'sd1 <<< (P-1)));
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("carry_out", 32'(carry_out), 32'(e.co));
                chk("overflow", 32'(overflow), 32'(e.ov));
                chk("latency", 32'(cyc - e.acc), 32'(N + 1));
            end
        end else if (q.size() > 0 && cyc > q[0].acc + N + 10) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done for op accepted at cycle %0d (now %0d)", q[0].acc, cyc);
            void'(q.pop_front());
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: ready=0 expected 1 after %0d cycles", n);
        end
    endtask

    task automatic scramble();
        add1     = P'($urandom);
        add0     = P'($urandom);
        sub      = 1'($urandom);
        carry_in = 1'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [P-1:0] a, input logic [P-1:0] b,
                         input logic s, input logic cin, input bit track);
        exp_t e;
        wait_ready();
        add1 = a; add0 = b; sub = s; carry_in = cin;
        start = 1'b1;
        @(posedge clk);
        if (track) begin
            e     = model(a, b, s, cin);
            e.acc = cyc;
            q.push_back(e);
        end
        #1 start = 1'b0;
        scramble();
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [P-1:0] a, input logic [P-1:0] b,
                          input logic s, input logic cin);
        issue(a, b, s, cin, 1'b1);
        drain();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; carry_in = 1'b0;
        add1 = '0; add0 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_sum", 32'(sum), 32'h0);
        chk("reset_ready", 32'(ready), 32'h1);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_carry_out", 32'(carry_out), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);

        // Extra starts and operand changes while busy must not disturb the op.
        begin
            int n = 0;
            issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
            chk("busy_ready_run", 32'(ready), 32'h0);
            scramble();
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            while (!done && n < 20) begin
                chk("busy_ready_run", 32'(ready), 32'h0);
                @(negedge clk);
                n++;
            end
            chk("busy_ready_done", 32'(ready), 32'h0);
            scramble();
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            chk("busy_back_idle_ready", 32'(ready), 32'h1);
            chk("busy_back_idle_done", 32'(done), 32'h0);
            chk("busy_sum_held", 32'(sum), 32'h2233);
            repeat (6) @(negedge clk);
        end

        // Reset during RUN aborts the op with no done pulse.
        issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_sum", 32'(sum), 32'h0);
        chk("abort_ready", 32'(ready), 32'h1);
        chk("abort_done", 32'(done), 32'h0);
        repeat (8) @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

        // Reset coinciding with start: start is lost.
        add1 = 16'h00F0; add0 = 16'h000F; sub = 1'b0; carry_in = 1'b0;
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_ready", 32'(ready), 32'h1);
        chk("rst_start_sum", 32'(sum), 32'h0);
        repeat (8) @(negedge clk);

        // Randomized back-to-back operations.
        for (int i = 0; i < 40; i++) begin
            issue(P'($urandom), P'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        drain();
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
